// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// funct3 encodings, and the alignment / legality rules applied at accept.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } lsu_state_e;

  localparam int unsigned TimeoutDefault = 255;

  localparam logic [2:0] F3Lb      = 3'b000;
  localparam logic [2:0] F3Lh      = 3'b001;
  localparam logic [2:0] F3Lw      = 3'b010;
  localparam logic [2:0] F3Ld      = 3'b011;
  localparam logic [2:0] F3Lbu     = 3'b100;
  localparam logic [2:0] F3Lhu     = 3'b101;
  localparam logic [2:0] F3Lwu     = 3'b110;
  localparam logic [2:0] F3LoadBad = 3'b111;

  localparam logic [2:0] F3Sb = 3'b000;
  localparam logic [2:0] F3Sh = 3'b001;
  localparam logic [2:0] F3Sw = 3'b010;
  localparam logic [2:0] F3Sd = 3'b011;

  // funct3[1:0] encodes log2 of the access size for both loads and stores.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    logic mis;
    unique case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = addr_lo[0];
      2'd2:    mis = |addr_lo[1:0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

  function automatic logic lsu_illegal(input logic is_load, input logic [2:0] funct3);
    return is_load ? (funct3 == F3LoadBad) : (funct3 > F3Sd);
  endfunction

endpackage

// File: rtl/store_aligner.sv
// Combinational byte-lane steering: builds byte enables and lane-shifted
// store data from the access size and byte offset within the doubleword.
module store_aligner #(
  parameter int unsigned N = 64
) (
  input  logic [1:0]                 size_i,
  input  logic [$clog2(N/8)-1:0]     offset_i,
  input  logic [N-1:0]               data_i,
  output logic [N/8-1:0]             be_o,
  output logic [N-1:0]               wdata_o
);

  localparam int unsigned NB = N / 8;

  logic [NB-1:0] size_mask;

  always_comb begin
    size_mask = '0;
    unique case (size_i)
      2'd0:    size_mask = NB'(8'h01);
      2'd1:    size_mask = NB'(8'h03);
      2'd2:    size_mask = NB'(8'h0F);
      default: size_mask = NB'(8'hFF);
    endcase
  end

  assign be_o    = size_mask << offset_i;
  assign wdata_o = data_i << {offset_i, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one op, issues a bus request,
// waits for data/ack with a timeout, and returns a one-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned N       = 64,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_load,
  input  logic                       req_store,
  input  logic [2:0]                 req_funct3,
  input  logic [N-1:0]               req_addr,
  input  logic [N-1:0]               req_wdata,
  output logic                       mem_req,
  input  logic                       mem_gnt,
  output logic                       mem_we,
  output logic [N-1:0]               mem_addr,
  output logic [N-1:0]               mem_wdata,
  output logic [N/8-1:0]             mem_be,
  input  logic                       mem_rvalid,
  input  logic [N-1:0]               mem_readData,
  output logic                       rsp_valid,
  output logic                       rsp_err,
  output logic [N-1:0]               rsp_readData,
  output logic [2:0]                 rsp_funct3,
  output logic [$clog2(N/8)-1:0]     rsp_byteOffset,
  output logic                       rsp_isLoad
);

  localparam int unsigned OffW = $clog2(N / 8);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lsu_state_e    state_q, state_d;
  logic [N-1:0]  addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          is_load_q, is_load_d;
  logic          err_q, err_d;
  logic [N-1:0]  rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic          bad_op;
  logic [N/8-1:0] aligned_be;
  logic [N-1:0]  aligned_wdata;

  assign bad_op = lsu_illegal(req_load, req_funct3) ||
                  lsu_misaligned(req_funct3[1:0], req_addr[2:0]);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    is_load_d = is_load_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && (req_load || req_store)) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          funct3_d  = req_funct3;
          is_load_d = req_load;
          rdata_d   = '0;
          cnt_d     = '0;
          err_d     = bad_op;
          state_d   = bad_op ? StResp : StReq;
        end
      end
      StReq: begin
        if (mem_gnt) begin
          cnt_d = '0;
          if (mem_rvalid) begin
            if (is_load_q) rdata_d = mem_readData;
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          if (is_load_q) rdata_d = mem_readData;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      is_load_q <= is_load_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  store_aligner #(
    .N(N)
  ) u_store_aligner (
    .size_i  (funct3_q[1:0]),
    .offset_i(addr_q[OffW-1:0]),
    .data_i  (wdata_q),
    .be_o    (aligned_be),
    .wdata_o (aligned_wdata)
  );

  // Bus fields are only driven while requesting so idle bus lines stay quiet.
  assign req_ready      = (state_q == StIdle);
  assign mem_req        = (state_q == StReq);
  assign mem_we         = mem_req && !is_load_q;
  assign mem_addr       = mem_req ? {addr_q[N-1:OffW], {OffW{1'b0}}} : '0;
  assign mem_be         = mem_req ? (is_load_q ? '1 : aligned_be) : '0;
  assign mem_wdata      = mem_we ? aligned_wdata : '0;

  assign rsp_valid      = (state_q == StResp);
  assign rsp_err        = rsp_valid && err_q;
  assign rsp_readData   = rdata_q;
  assign rsp_funct3     = funct3_q;
  assign rsp_byteOffset = addr_q[OffW-1:0];
  assign rsp_isLoad     = is_load_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter N, default 64: data and address width in bits; N/8 byte lanes.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before bus-error response.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low; ports SHALL be named clk and rst_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  pipeline memory op valid; req_ready  out  1  block can accept.
REQ-007 req_load  in  1  op is load; req_store  in  1  op is store (never both).
REQ-008 req_funct3  in  3  RISC-V load/store funct3.
REQ-009 req_addr  in  N  effective byte address; req_wdata  in  N  store data, LSB-aligned.
REQ-010 mem_req  out  1  bus request; mem_gnt  in  1  request accepted.
REQ-011 mem_we  out  1  write; mem_addr  out  N  doubleword-aligned address (low log2(N/8) bits zero).
REQ-012 mem_wdata  out  N  lane-shifted store data; mem_be  out  N/8  byte enables.
REQ-013 mem_rvalid  in  1  read data / write ack; mem_readData  in  N  raw doubleword.
REQ-014 rsp_valid  out  1  one-cycle completion pulse; rsp_err  out  1  misaligned, illegal or timeout.
REQ-015 rsp_readData  out  N  captured raw doubleword; rsp_funct3  out  3; rsp_byteOffset  out  log2(N/8); rsp_isLoad  out  1 -- sideband for the downstream load extender.

Function
REQ-016 FSM states IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: req_valid & (req_load | req_store) accepted; address, funct3, wdata, op type registered in that cycle.
REQ-018 Legal accepted op -> REQ next cycle; misaligned or illegal op -> RESP with rsp_err=1, no mem_req ever asserted.
REQ-019 Misaligned: halfword addr[0]!=0; word addr[1:0]!=0; doubleword addr[2:0]!=0; byte never misaligned.
REQ-020 Illegal: load funct3 3'b111; store funct3 above 3'b011.
REQ-021 REQ: mem_req=1 with mem_we, mem_addr, mem_wdata, mem_be held stable until mem_gnt; on mem_gnt -> WAIT, or -> RESP if mem_rvalid also asserted that cycle.
REQ-022 mem_be = size mask (1/3/15/255 for SB/SH/SW/SD) shifted left by byte offset; mem_wdata = req_wdata shifted left by 8*offset; loads drive mem_be all ones.
REQ-023 WAIT: on mem_rvalid capture mem_readData into rsp_readData, -> RESP; mem_rvalid outside REQ/WAIT SHALL be ignored.
REQ-024 WAIT cycle counter, cleared on WAIT entry; reaching TIMEOUT without mem_rvalid -> RESP with rsp_err=1, rsp_readData unchanged.
REQ-025 RESP: rsp_valid=1 for exactly one cycle, sideband stable, then -> IDLE; earliest new accept is the cycle after RESP.
REQ-026 Minimum latency for legal op with gnt in REQ and rvalid in first WAIT cycle: accept cycle T, rsp_valid at T+3.
REQ-027 For stores rsp_readData SHALL be 0 and rsp_isLoad 0.

Reset
REQ-028 On rst_n low: state IDLE, counter 0, all outputs 0 except req_ready=1, asynchronously.
REQ-029 Reset mid-transaction SHALL abandon the op with no rsp_valid; memory-side late mem_rvalid after release SHALL be ignored.

Structure
REQ-030 Package lsu_pkg SHALL hold the state enum, funct3 load/store constants and TIMEOUT default.
REQ-031 Sub-module store_aligner (combinational) SHALL generate mem_be and mem_wdata from funct3, offset and data.

Verification
REQ-032 SB addr 0x1003 data 0xAB, gnt immediate, rvalid next -> mem_addr 0x1000, mem_be 0x08, mem_wdata 0xAB000000, rsp_valid at T+3, rsp_err 0.
REQ-033 LW addr 0x2004, mem_readData 0x89ABCDEF_01234567 -> rsp_readData equal, rsp_byteOffset 4, rsp_funct3 010, rsp_isLoad 1.
REQ-034 LH addr 0x2001 -> no mem_req, rsp_valid at T+1 with rsp_err 1.
REQ-035 LD with gnt held low 5 cycles -> mem_req and fields stable 5 cycles, completes after gnt.
REQ-036 LD with no rvalid -> rsp_err 1 after TIMEOUT WAIT cycles; rst_n pulse in WAIT -> IDLE, req_ready 1, no rsp_valid.
